// File: rtl/smg_pkg.sv
// Shared definitions for the seven-segment scan driver.
//   scan_state_t : scan FSM encoding (blank gap / digit on)
//   SMG_OFF      : display bus value with every digit and segment dark
//   hex7seg()    : nibble -> active-high segments, bit order {g,f,e,d,c,b,a}
package smg_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } scan_state_t;

    localparam logic [11:0] SMG_OFF = 12'hFFF;

    function automatic logic [6:0] hex7seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational hex-to-seven-segment decoder.
//   nibble : 4-bit hex digit
//   seg    : active-high segments {g,f,e,d,c,b,a}
module hex7seg_dec
    import smg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = hex7seg(nibble);
    end

endmodule

// File: rtl/smg_scan_driver.sv
// Four-digit multiplexed seven-segment scan driver.
// Shows a 16-bit hex value one digit at a time, with an all-off gap before
// each digit slot to suppress ghosting. New values from the register
// interface are held pending and only swapped into the displayed (shadow)
// copy at the end of a full frame, so a frame never mixes two values.
//   clk        : system clock
//   reset      : asynchronous, active-low reset
//   wr_en      : one-cycle write strobe
//   wr_data    : hex value, nibble i on digit i (digit 0 rightmost)
//   wr_dp      : decimal-point enables per digit
//   lz_blank   : 1 = blank leading zero digits
//   smg        : [11:8] digit selects (active-low, bit 8 = digit 0),
//                [7:0] segments {dp,g,f,e,d,c,b,a} (active-low)
//   frame_done : one-cycle pulse during the last ON cycle of digit 3
module smg_scan_driver
    import smg_pkg::*;
#(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [15:0] wr_data,
    input  logic [3:0]  wr_dp,
    input  logic        lz_blank,
    output logic [11:0] smg,
    output logic        frame_done
);

    localparam int CNT_MAX = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
    localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(SCAN_DIV - 1);
    // frame_done is registered, so it is launched one cycle early to line
    // up with the boundary cycle itself (needs SCAN_DIV >= 2).
    localparam logic [CNT_W-1:0] ON_PRE     = CNT_W'(SCAN_DIV - 2);

    scan_state_t      state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [1:0]       idx_reg;
    logic [15:0]      shadow_val_reg;
    logic [3:0]       shadow_dp_reg;
    logic [15:0]      pend_val_reg;
    logic [3:0]       pend_dp_reg;
    logic             pend_valid_reg;
    logic [11:0]      smg_reg;
    logic             frame_done_reg;

    logic [3:0]  cur_nibble;
    logic [6:0]  cur_seg;
    logic [3:0]  lz_cand;
    logic        digit_blank;
    logic [11:0] on_word;

    assign cur_nibble = shadow_val_reg[{idx_reg, 2'b00} +: 4];

    hex7seg_dec u_dec (
        .nibble (cur_nibble),
        .seg    (cur_seg)
    );

    // A digit is a leading-zero candidate when it and every digit to its
    // left are zero and its own decimal point is off. Digit 0 always shows.
    assign lz_cand[0] = 1'b0;
    generate
        for (genvar gi = 1; gi < 4; gi++) begin : g_lz
            assign lz_cand[gi] = (shadow_val_reg[15:4*gi] == '0) && !shadow_dp_reg[gi];
        end
    endgenerate

    assign digit_blank = lz_blank && lz_cand[idx_reg];

    always_comb begin
        on_word       = SMG_OFF;
        on_word[11:8] = digit_blank ? 4'hF : ~(4'b0001 << idx_reg);
        on_word[7]    = ~shadow_dp_reg[idx_reg];
        on_word[6:0]  = ~cur_seg;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_BLANK;
            cnt_reg        <= '0;
            idx_reg        <= 2'd0;
            shadow_val_reg <= 16'h0000;
            shadow_dp_reg  <= 4'h0;
            pend_val_reg   <= 16'h0000;
            pend_dp_reg    <= 4'h0;
            pend_valid_reg <= 1'b0;
            smg_reg        <= SMG_OFF;
            frame_done_reg <= 1'b0;
        end else begin
            frame_done_reg <= 1'b0;

            case (state_reg)
                ST_BLANK: begin
                    if (cnt_reg == BLANK_LAST) begin
                        state_reg <= ST_ON;
                        cnt_reg   <= '0;
                        smg_reg   <= on_word;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                ST_ON: begin
                    if (idx_reg == 2'd3 && cnt_reg == ON_PRE) begin
                        frame_done_reg <= 1'b1;
                    end
                    if (cnt_reg == ON_LAST) begin
                        state_reg <= ST_BLANK;
                        cnt_reg   <= '0;
                        smg_reg   <= SMG_OFF;
                        idx_reg   <= idx_reg + 2'd1;
                        // Frame boundary: promote the pending value.
                        if (idx_reg == 2'd3) begin
                            if (pend_valid_reg) begin
                                shadow_val_reg <= pend_val_reg;
                                shadow_dp_reg  <= pend_dp_reg;
                            end
                            pend_valid_reg <= 1'b0;
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                        // Refresh keeps lz_blank live during the slot.
                        smg_reg <= on_word;
                    end
                end
                default: begin
                    state_reg <= ST_BLANK;
                    cnt_reg   <= '0;
                    smg_reg   <= SMG_OFF;
                end
            endcase

            // Placed after the boundary logic so a write on the boundary
            // cycle stays pending for the following frame.
            if (wr_en) begin
                pend_val_reg   <= wr_data;
                pend_dp_reg    <= wr_dp;
                pend_valid_reg <= 1'b1;
            end
        end
    end

    assign smg        = smg_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_smg_scan_driver.sv
module tb_smg_scan_driver;

    localparam int SCAN_DIV  = 4;
    localparam int BLANK_CYC = 2;
    localparam int SLOT      = SCAN_DIV + BLANK_CYC;
    localparam int FRAME     = 4 * SLOT;

    typedef struct {
        int          k;
        logic [11:0] smg;
        logic        fd;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [15:0] wr_data;
    logic [3:0]  wr_dp;
    logic        lz_blank;
    logic [11:0] smg;
    logic        frame_done;

    int tests = 0;
    int fails = 0;

    exp_t exp_q[$];

    // Reference state: cycle count since reset release, displayed and
    // pending values, and the lz_blank level in force for this frame.
    int          m_k;
    logic [15:0] m_shadow;
    logic [3:0]  m_sdp;
    logic [15:0] m_pend;
    logic [3:0]  m_pdp;
    logic        m_pv;
    logic        m_lz;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    smg_scan_driver #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_data    (wr_data),
        .wr_dp      (wr_dp),
        .lz_blank   (lz_blank),
        .smg        (smg),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Expected display for cycle k: position within the frame picks the
    // slot; the first BLANK_CYC cycles of each slot are dark.
    function automatic exp_t expect_at(input int k, input logic [15:0] sh,
                                       input logic [3:0] sdp, input logic lz);
        exp_t e;
        int pos, slot, ph;
        logic [3:0] nib;
        logic [15:0] upper;
        pos   = k % FRAME;
        slot  = pos / SLOT;
        ph    = pos % SLOT;
        e.k   = k;
        e.fd  = (pos == FRAME - 1);
        e.smg = 12'hFFF;
        if (ph >= BLANK_CYC) begin
            upper = sh >> (4 * slot);
            nib   = upper[3:0];
            if (lz && slot > 0 && upper == 16'h0 && !sdp[slot])
                e.smg[11:8] = 4'hF;
            else
                e.smg[11:8] = ~(4'(1 << slot));
            e.smg[7]   = ~sdp[slot];
            e.smg[6:0] = ~seg_tab[nib];
        end
        return e;
    endfunction

    task automatic model_reset();
        m_k      = 0;
        m_shadow = 16'h0;
        m_sdp    = 4'h0;
        m_pend   = 16'h0;
        m_pdp    = 4'h0;
        m_pv     = 1'b0;
        m_lz     = lz_blank;
    endtask

    // One clock cycle: entered at posedge+1. lz_blank is only moved on the
    // frame's last cycle so it is steady across every ON slot.
    task automatic step(input logic we, input logic [15:0] d, input logic [3:0] dp,
                        input logic lz_req);
        int pos;
        pos = m_k % FRAME;
        exp_q.push_back(expect_at(m_k, m_shadow, m_sdp, m_lz));
        wr_en   = we;
        wr_data = d;
        wr_dp   = dp;
        if (pos == FRAME - 1) lz_blank = lz_req;
        if (we) $display("[TB] write k=%0d pos=%0d data=%h dp=%b", m_k, pos, d, dp);
        @(posedge clk);
        #1;
        if (pos == FRAME - 1) begin
            if (m_pv) begin
                m_shadow = m_pend;
                m_sdp    = m_pdp;
            end
            m_pv = 1'b0;
            m_lz = lz_blank;
        end
        if (we) begin
            m_pend = d;
            m_pdp  = dp;
            m_pv   = 1'b1;
        end
        m_k++;
        wr_en = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 16'h0, 4'h0, lz_blank);
    endtask

    task automatic idle_to(input int pos);
        for (int i = 0; i < FRAME && (m_k % FRAME) != pos; i++) step(1'b0, 16'h0, 4'h0, lz_blank);
    endtask

    task automatic check_off(input string name);
        tests++;
        if (smg !== 12'hFFF || frame_done !== 1'b0) begin
            fails++;
            $display("FAIL %s smg=%h frame_done=%b expected smg=fff frame_done=0",
                     name, smg, frame_done);
        end
    endtask

    // Monitor: every cycle with an outstanding expectation is compared.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests++;
                if (smg !== e.smg || frame_done !== e.fd) begin
                    fails++;
                    $display("FAIL scan k=%0d pos=%0d smg=%h frame_done=%b expected smg=%h frame_done=%b",
                             e.k, e.k % FRAME, smg, frame_done, e.smg, e.fd);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] rd;
        logic [3:0]  rdp;
        reset    = 1'b0;
        wr_en    = 1'b0;
        wr_data  = 16'h0;
        wr_dp    = 4'h0;
        lz_blank = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_off("reset_hold");
        reset = 1'b1;
        model_reset();

        // Idle scan of 0000.
        idle(30);

        // Mid-frame write appears only after the next boundary.
        idle_to(10);
        step(1'b1, 16'h1234, 4'b0001, 1'b0);
        idle(50);

        // Last write in a frame wins.
        idle_to(3);
        step(1'b1, 16'hAAAA, 4'h0, 1'b0);
        idle(5);
        step(1'b1, 16'h5555, 4'h0, 1'b0);
        idle(40);

        // Write exactly on the boundary cycle with an older value pending.
        idle_to(8);
        step(1'b1, 16'h1111, 4'h0, 1'b0);
        idle_to(FRAME - 1);
        step(1'b1, 16'hBEEF, 4'h0, 1'b0);
        idle(2 * FRAME);

        // Leading-zero blanking, then a dp that keeps digit 2 visible.
        idle_to(5);
        step(1'b1, 16'h0030, 4'b0000, 1'b0);
        idle_to(FRAME - 1);
        step(1'b0, 16'h0, 4'h0, 1'b1);
        idle(30);
        idle_to(4);
        step(1'b1, 16'h0030, 4'b0100, 1'b1);
        idle(2 * FRAME);

        // Randomised writes, values biased towards leading zeros.
        for (int i = 0; i < 800; i++) begin
            rd  = 16'($urandom);
            rdp = 4'($urandom);
            if ($urandom_range(0, 1) == 1) rd = rd >> (4 * $urandom_range(1, 4));
            if ($urandom_range(0, 1) == 1) rdp = 4'h0;
            step($urandom_range(0, 7) == 0, rd, rdp, 1'($urandom_range(0, 1)));
        end

        // Reset during digit 2 ON with a write pending.
        idle_to(FRAME - 1);
        step(1'b0, 16'h0, 4'h0, 1'b0);
        idle_to(4);
        step(1'b1, 16'h9876, 4'b1111, 1'b0);
        idle_to(2 * SLOT + BLANK_CYC + 1);
        #2;
        reset = 1'b0;
        #1;
        check_off("reset_async");
        repeat (2) @(posedge clk);
        #1;
        check_off("reset_held");
        reset = 1'b1;
        model_reset();
        idle(2 * FRAME + 10);

        @(negedge clk);
        #1;
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain queue_size=%0d expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
